// File: rtl/ss_rvc_dmem_arb.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ ss_rvc cores.
// Define SS_RVC_DMEM_ARB_LOCK_EN to build the ownership lock with forced release after LOCK_MAX cycles.
module ss_rvc_dmem_arb #(
    parameter int NUM_REQ  = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                     QClk,
    input  logic                     RstQnnnH,
    input  logic [NUM_REQ-1:0]       ReqQ103H,
    input  logic [NUM_REQ-1:0]       ReqWrEnQ103H,
    input  logic [NUM_REQ-1:0]       ReqLockQ103H,
    input  logic [NUM_REQ-1:0][31:0] ReqAddrQ103H,
    input  logic [NUM_REQ-1:0][31:0] ReqWrDataQ103H,
    output logic [NUM_REQ-1:0]       GntQ103H,
    output logic [31:0]              AddressDmQ104H,
    output logic [31:0]              WrDataDmQ104H,
    output logic                     RdEnDmQ104H,
    output logic                     WrEnDmQ104H,
    input  logic [31:0]              RdDataDmQ105H,
    output logic [NUM_REQ-1:0]       RspVldQ105H,
    output logic [31:0]              RspRdDataQ105H
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [IW-1:0]      rr_win;
    logic               rr_vld;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               xfer;
    logic               xfer_wr;
    logic [NUM_REQ-1:0] ld_vec;
    logic [NUM_REQ-1:0] ld_q104_reg;

    // Scan from the largest offset down so the closest requester after rr_ptr wins.
    always_comb begin : rr_search
        int cand;
        cand   = 0;
        rr_win = '0;
        rr_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (ReqQ103H[cand[IW-1:0]]) begin
                rr_vld = 1'b1;
                rr_win = cand[IW-1:0];
            end
        end
    end

`ifdef SS_RVC_DMEM_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [7:0] CNT_LAST = 8'(LOCK_MAX - 1);
    localparam logic [7:0] CNT_MAX  = 8'(LOCK_MAX);

    state_t        state_reg, state_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [7:0]    lock_cnt_reg, lock_cnt_next;

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            lock_cnt_reg <= '0;
            rr_ptr_reg   <= IW'(NUM_REQ - 1);
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            lock_cnt_reg <= lock_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    always_comb begin
        gnt_idx       = rr_win;
        gnt_vld       = rr_vld;
        state_next    = state_reg;
        owner_next    = owner_reg;
        lock_cnt_next = lock_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (rr_vld) begin
                    rr_ptr_next = rr_win;
                    if (ReqLockQ103H[rr_win]) begin
                        state_next    = LOCKED;
                        owner_next    = rr_win;
                        lock_cnt_next = '0;
                    end
                end
            end
            LOCKED: begin
                gnt_idx = owner_reg;
                gnt_vld = ReqQ103H[owner_reg];
                if (lock_cnt_reg < CNT_MAX) begin
                    lock_cnt_next = lock_cnt_reg + 8'd1;
                end
                // Releasing transfer or forced timeout; handing rr_ptr the owner favours the next core.
                if ((gnt_vld && !ReqLockQ103H[owner_reg]) || (lock_cnt_reg == CNT_LAST)) begin
                    state_next  = IDLE;
                    rr_ptr_next = owner_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    logic       unused_lock;
    logic [7:0] unused_lock_max;

    assign unused_lock     = ^ReqLockQ103H;
    assign unused_lock_max = 8'(LOCK_MAX);

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            rr_ptr_reg <= IW'(NUM_REQ - 1);
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        gnt_idx     = rr_win;
        gnt_vld     = rr_vld;
        rr_ptr_next = rr_ptr_reg;
        if (rr_vld) begin
            rr_ptr_next = rr_win;
        end
    end
`endif

    // Grant is forced low while reset is held so no core sees a phantom transfer.
    assign xfer    = gnt_vld & RstQnnnH;
    assign xfer_wr = ReqWrEnQ103H[gnt_idx];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign GntQ103H[gi] = xfer && (gnt_idx == IW'(gi));
        assign ld_vec[gi]   = GntQ103H[gi] && !ReqWrEnQ103H[gi];
    end

    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            AddressDmQ104H <= '0;
            WrDataDmQ104H  <= '0;
            RdEnDmQ104H    <= 1'b0;
            WrEnDmQ104H    <= 1'b0;
            ld_q104_reg    <= '0;
            RspVldQ105H    <= '0;
        end else begin
            RdEnDmQ104H <= xfer && !xfer_wr;
            WrEnDmQ104H <= xfer && xfer_wr;
            if (xfer) begin
                AddressDmQ104H <= ReqAddrQ103H[gnt_idx];
                WrDataDmQ104H  <= ReqWrDataQ103H[gnt_idx];
            end
            ld_q104_reg <= ld_vec;
            RspVldQ105H <= ld_q104_reg;
        end
    end

    assign RspRdDataQ105H = RdDataDmQ105H;

endmodule
